// File: rtl/piso_pkg.sv
// piso_pkg: word width and word type shared by the PISO shifter and its deserializer
package piso_pkg;
  localparam int PISO_W = 4;
  typedef logic [PISO_W-1:0] word_t;
endpackage

// File: rtl/sipo_fifo.sv
// sipo_fifo: small word FIFO with a registered head word and valid/ready pop
module sipo_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd;
  logic [AW:0] cnt, nxt_cnt;
  logic do_pop, do_push;
  logic [WIDTH-1:0] head;
  assign full = cnt == (AW+1)'(DEPTH);
  assign valid = cnt != '0;
  // A word arriving in the slot that becomes the head bypasses memory into the output register
  always_comb begin
    do_pop = pop && valid;
    do_push = push && (!full || do_pop);
    nxt_rd = rd_ptr + AW'(do_pop);
    nxt_cnt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head = (do_push && wr_ptr == nxt_rd) ? din : mem[nxt_rd];
  end
  // Pointers, storage and the head register; dout holds its last word once empty
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dout <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= nxt_rd;
      cnt <= nxt_cnt;
      if (nxt_cnt != '0) dout <= head;
    end
  end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-to-parallel deserializer with an output word FIFO
module sipo_deser
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   sin,
  input  logic                   sin_en,
  input  logic                   sync_clr,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(WIDTH):0] bit_cnt,
  output logic                   overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word;
  logic complete, full;
  assign word = {shreg, sin};
  assign complete = sin_en && !sync_clr && bit_cnt == CW'(WIDTH - 1);
  // Collect bits MSB first; the word's last bit goes straight to the FIFO, so only WIDTH-1 are stored
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg <= '0;
      bit_cnt <= '0;
    end else if (sync_clr) begin
      shreg <= '0;
      bit_cnt <= '0;
    end else if (sin_en) begin
      shreg <= word[WIDTH-2:0];
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end
  // Sticky flag for a completed word dropped on a full FIFO that is not popping
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) overflow <= 1'b0;
    else if (complete && full && !(dout_valid && dout_ready)) overflow <= 1'b1;
  end
  sipo_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clr_n(clr_n),
    .push(complete),
    .din(word),
    .full(full),
    .pop(dout_ready),
    .dout(dout),
    .valid(dout_valid)
  );
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: vector table, directed corner sequences and random traffic against a queue model
module tb_sipo_deser;
  import piso_pkg::*;
  localparam int W = 4;
  localparam int D = 2;
  logic clk, clr_n, sin, sin_en, sync_clr, dout_ready, dout_valid, overflow;
  logic [W-1:0] dout;
  logic [2:0] bit_cnt;
  int checks, fails, nwords, cycles;
  bit pbits[$];
  logic [W-1:0] q[$];
  logic m_ovf;
  logic [W-1:0] m_last;
  typedef struct {
    logic s, e, c, r;
    logic v;
    logic [W-1:0] d;
    logic [2:0] n;
    logic o;
  } vec_t;
  vec_t tbl[12];

  sipo_deser #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_en(sin_en), .sync_clr(sync_clr),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt), .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    pbits.delete();
    q.delete();
    m_ovf = 0;
    m_last = '0;
  endtask

  task automatic chk_model(input string n);
    chk({n, ".valid"}, 32'(dout_valid), 32'(q.size() > 0));
    chk({n, ".dout"}, 32'(dout), 32'(m_last));
    chk({n, ".bit_cnt"}, 32'(bit_cnt), 32'(pbits.size()));
    chk({n, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input logic s, input logic e, input logic c, input logic r, input string n);
    bit do_pop;
    int w;
    sin = s;
    sin_en = e;
    sync_clr = c;
    dout_ready = r;
    do_pop = q.size() > 0 && r;
    @(posedge clk);
    if (do_pop) q.delete(0);
    if (c) pbits.delete();
    else if (e) begin
      pbits.push_back(s);
      if (pbits.size() == W) begin
        w = 0;
        foreach (pbits[i]) w = w * 2 + int'(pbits[i]);
        pbits.delete();
        nwords++;
        if (q.size() < D) q.push_back(w[W-1:0]);
        else m_ovf = 1;
      end
    end
    if (q.size() > 0) m_last = q[0];
    @(negedge clk);
    chk_model(n);
  endtask

  task automatic send(input logic [W-1:0] wd, input logic r, input string n);
    for (int i = W - 1; i >= 0; i--) cyc(wd[i], 1'b1, 1'b0, r, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clr_n = 0;
    sin = 1'($urandom);
    sin_en = 1'($urandom);
    sync_clr = 0;
    dout_ready = 0;
    model_clear();
    #1 chk_model("reset_async");
    @(negedge clk);
    sin = 1'($urandom);
    sin_en = 1'($urandom);
    @(negedge clk);
    sin_en = 0;
    #3 clr_n = 1;
    @(negedge clk);
    chk_model("reset_release");
  endtask

  initial begin
    word_t pd;
    checks = 0;
    fails = 0;
    nwords = 0;
    clr_n = 1;
    sin = 0;
    sin_en = 0;
    sync_clr = 0;
    dout_ready = 0;
    model_clear();
    #1 clr_n = 0;
    #1 chk_model("power_on_reset");

    do_reset();
    tbl[0]  = '{1, 1, 0, 1, 0, 4'h0, 3'd1, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 4'h0, 3'd2, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 4'h0, 3'd0, 0};
    tbl[3]  = '{0, 1, 0, 1, 0, 4'h0, 3'd1, 0};
    tbl[4]  = '{1, 1, 0, 1, 0, 4'h0, 3'd2, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 4'h0, 3'd3, 0};
    tbl[6]  = '{0, 1, 0, 1, 1, 4'h6, 3'd0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 4'h6, 3'd0, 0};
    tbl[8]  = '{1, 1, 0, 1, 0, 4'h6, 3'd1, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 4'h6, 3'd2, 0};
    tbl[10] = '{1, 1, 0, 1, 0, 4'h6, 3'd3, 0};
    tbl[11] = '{1, 1, 1, 1, 0, 4'h6, 3'd0, 0};
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].e, tbl[i].c, tbl[i].r, "tbl_model");
      chk($sformatf("tbl[%0d].valid", i), 32'(dout_valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d].dout", i), 32'(dout), 32'(tbl[i].d));
      chk($sformatf("tbl[%0d].bit_cnt", i), 32'(bit_cnt), 32'(tbl[i].n));
      chk($sformatf("tbl[%0d].overflow", i), 32'(overflow), 32'(tbl[i].o));
    end

    do_reset();
    pd = 4'b1011;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(pd[i], 1, 0, 1, "piso_w0");
      if (i > 0) chk("piso_w0_early_valid", 32'(dout_valid), 0);
    end
    chk("piso_w0_dout", 32'(dout), 32'hB);
    chk("piso_w0_valid", 32'(dout_valid), 1);
    pd = 4'b1100;
    for (int i = W - 1; i >= 0; i--) cyc(pd[i], 1, 0, 1, "piso_w1");
    chk("piso_w1_dout", 32'(dout), 32'hC);
    chk("piso_w1_valid", 32'(dout_valid), 1);

    do_reset();
    send(4'h3, 0, "bp");
    send(4'hA, 0, "bp");
    send(4'h5, 0, "bp");
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_head", 32'(dout), 32'h3);
    cyc(0, 0, 0, 1, "bp_pop0");
    chk("bp_second", 32'(dout), 32'hA);
    cyc(0, 0, 0, 1, "bp_pop1");
    chk("bp_empty", 32'(dout_valid), 0);
    chk("bp_overflow_sticky", 32'(overflow), 1);

    do_reset();
    send(4'h3, 0, "fullpop");
    send(4'hA, 0, "fullpop");
    for (int i = 0; i < W - 1; i++) cyc(1, 1, 0, 0, "fullpop_f");
    cyc(1, 1, 0, 1, "fullpop_last");
    chk("fullpop_overflow", 32'(overflow), 0);
    chk("fullpop_head", 32'(dout), 32'hA);
    cyc(0, 0, 0, 1, "fullpop_drain0");
    chk("fullpop_f", 32'(dout), 32'hF);
    cyc(0, 0, 0, 1, "fullpop_drain1");
    chk("fullpop_empty", 32'(dout_valid), 0);

    do_reset();
    send(4'h9, 0, "async");
    cyc(1, 1, 0, 0, "async_part");
    cyc(0, 1, 0, 0, "async_part");
    #1 clr_n = 0;
    #1 model_clear();
    chk("async_valid_drop", 32'(dout_valid), 0);
    chk("async_bit_cnt", 32'(bit_cnt), 0);
    chk("async_dout", 32'(dout), 0);
    #2 clr_n = 1;
    send(4'h7, 1, "async_fresh");
    chk("async_fresh_word", 32'(dout), 32'h7);

    do_reset();
    nwords = 0;
    cycles = 0;
    while (nwords < 1000 && cycles < 20000) begin
      cyc(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0,
          (cycles / 500) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0, "rand");
      cycles++;
    end
    chk("rand_words_done", 32'(nwords >= 1000), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
